// File: rtl/demux_1_4_reg.sv
// 1-to-4 registered demultiplexer: one holding register per channel, valid/ready on both sides.
// Latency 1 cycle; in_ready drops only when the addressed channel is full and not being drained.
module demux_1_4_reg #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data0,
    output logic [WIDTH-1:0] out_data1,
    output logic [WIDTH-1:0] out_data2,
    output logic [WIDTH-1:0] out_data3,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [7:0]       drop_cnt
);

    logic [WIDTH-1:0] data_q [4];
    logic [WIDTH-1:0] data_d [4];
    logic [3:0]       valid_q, valid_d;
    logic [7:0]       drop_q, drop_d;
    logic             accept;
    logic [3:0]       pop;
    logic [3:0]       load;

    assign in_ready = ~valid_q[in_sel] | out_ready[in_sel];
    assign accept   = in_valid & in_ready;
    assign pop      = valid_q & out_ready;

    always_comb begin
        load   = 4'b0000;
        drop_d = drop_q;
        if (accept) begin
            load[in_sel] = 1'b1;
        end
        // Saturate rather than wrap so a long stall still reads as "many".
        if (in_valid && !in_ready && drop_q != 8'hFF) begin
            drop_d = drop_q + 8'd1;
        end
        for (int k = 0; k < 4; k++) begin
            data_d[k]  = load[k] ? in_data : data_q[k];
            valid_d[k] = load[k] | (valid_q[k] & ~pop[k]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 4; k++) begin
                data_q[k] <= '0;
            end
            valid_q <= 4'b0000;
            drop_q  <= 8'd0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                data_q[k] <= data_d[k];
            end
            valid_q <= valid_d;
            drop_q  <= drop_d;
        end
    end

    assign out_data0 = data_q[0];
    assign out_data1 = data_q[1];
    assign out_data2 = data_q[2];
    assign out_data3 = data_q[3];
    assign out_valid = valid_q;
    assign drop_cnt  = drop_q;

endmodule

// File: doc/demux_1_4_reg.md
DEMUX_1_4_REG -- requirements
Module: demux_1_4_reg

Interface
REQ-001 Parameter: WIDTH, 4, data width in bits of the input and of each output channel.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_data  input  WIDTH  data word offered for routing.
REQ-005 in_sel  input  2  destination channel index 0..3 (sel1 = bit 1, sel0 = bit 0).
REQ-006 in_valid  input  1  in_data/in_sel valid this cycle.
REQ-007 in_ready  output  1  block accepts the offered word this cycle.
REQ-008 out_data0..out_data3  output  WIDTH each  per-channel holding register contents.
REQ-009 out_valid  output  4  bit k set = channel k holds an undelivered word.
REQ-010 out_ready  input  4  bit k set = consumer k takes channel k's word this cycle.
REQ-011 drop_cnt  output  8  count of cycles with in_valid=1 and in_ready=0, saturating.

Function
REQ-012 Each channel k SHALL hold one word in a 1-entry register plus a valid flag; it is a 1-to-4 registered demultiplexer with valid/ready on both sides.
REQ-013 Input handshake: accept = in_valid & in_ready; output handshake k: pop_k = out_valid[k] & out_ready[k].
REQ-014 in_ready SHALL equal ~out_valid[in_sel] | out_ready[in_sel], combinationally; it SHALL be independent of in_valid.
REQ-015 On accept, out_data<in_sel> SHALL load in_data and out_valid[in_sel] SHALL be 1 from the next cycle; latency input-to-output = 1 cycle.
REQ-016 Simultaneous pop_k and accept to channel k SHALL load the new word and keep out_valid[k]=1, with no bubble and no loss.
REQ-017 pop_k without an accept to k SHALL clear out_valid[k] next cycle; out_data<k> SHALL keep its last value.
REQ-018 Channels not addressed by in_sel SHALL be unaffected by the input; pops on different channels in the same cycle SHALL all take effect.
REQ-019 out_ready[k] while out_valid[k]=0 SHALL have no effect.
REQ-020 out_data<k> SHALL change only on an accept to channel k or on reset.
REQ-021 drop_cnt SHALL increment by 1 on each cycle with in_valid=1 and in_ready=0, and SHALL saturate at 255, with no wrap.
REQ-022 in_data and in_sel values while in_valid=0 SHALL NOT alter any state.

Reset
REQ-023 With rst=1 at a rising edge, out_valid=4'b0000, out_data0..3=0 and drop_cnt=0 SHALL hold on the next cycle, overriding any concurrent accept or pop.
REQ-024 Reset mid-operation SHALL discard all held words; in_ready SHALL be 1 in the first cycle after reset is released.
REQ-025 In a cycle with rst=1, in_ready SHALL still follow REQ-014 from the current state; accepts in that cycle SHALL be lost.

Verification
REQ-026 After reset, in_sel=2, in_data=4'hA, in_valid=1 for 1 cycle, out_ready=0 -> next cycle out_valid=4'b0100, out_data2=4'hA, others 0.
REQ-027 Channel 1 full (4'h3), out_ready=0, offer in_sel=1, data 4'h5 -> in_ready=0; drop_cnt increments by 1 per stalled cycle; out_data1 stays 4'h3.
REQ-028 Channel 1 full (4'h3), same cycle out_ready[1]=1 and offer in_sel=1, data 4'h5 -> in_ready=1; next cycle out_valid[1]=1, out_data1=4'h5.
REQ-029 Back-to-back words 1,2,3,4 to sel 0,1,2,3 with out_ready=4'b1111 -> each out_valid bit pulses 1 cycle after its accept; no drops; drop_cnt=0.
REQ-030 Hold a stall (channel full, in_valid=1) for 300 cycles -> drop_cnt reaches 255 and holds 255.
REQ-031 All channels full, assert rst for 1 cycle with a concurrent accept -> next cycle out_valid=0, all out_data=0, drop_cnt=0, in_ready=1.
